// File: rtl/move_sequencer_if.sv
// Move-command handshake between the solver move queue and the move sequencer.
// The queue side uses the master modport; the sequencer uses the slave modport.
interface move_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_face;
  logic       cmd_dir;
  logic       cmd_half;

  modport master (
    output cmd_valid,
    output cmd_face,
    output cmd_dir,
    output cmd_half,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_face,
    input  cmd_dir,
    input  cmd_half,
    output cmd_ready
  );
endinterface

// File: rtl/move_sequencer.sv
// Runs one cube-face turn at a time on six stepper drivers: enable, settle, step, hold, done.
// Optional MOVE_SEQUENCER_RAMP_EN stretches STEP_LO to 3 ticks on the first/last 4 pulses.
module move_sequencer #(
  parameter int TICK_DIV          = 62500,
  parameter int STEPS_PER_QUARTER = 50,
  parameter int SETTLE_TICKS      = 4
) (
  input  logic               clock,
  input  logic               reset,
  move_sequencer_if.slave    cmd,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [5:0]         o_step,
  output logic [5:0]         o_dir,
  output logic [5:0]         o_enable
);

  localparam int TICK_W    = $clog2(TICK_DIV);
  // Extra headroom so the ramp comparison (count + 4) never overflows.
  localparam int STEP_W    = $clog2(2 * STEPS_PER_QUARTER + 5);
  localparam int PHASE_MAX = (SETTLE_TICKS > 3) ? SETTLE_TICKS : 3;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [TICK_W-1:0]  LAST_TICK    = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  N_QUARTER    = STEP_W'(STEPS_PER_QUARTER);
  localparam logic [STEP_W-1:0]  N_HALF       = STEP_W'(2 * STEPS_PER_QUARTER);
  localparam logic [PHASE_W-1:0] SETTLE_LAST  = PHASE_W'(SETTLE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_STEP_HI,
    S_STEP_LO,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [PHASE_W-1:0]  r_phase_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [2:0]          r_face;
  logic                r_dir;
  logic                r_half;
  logic                r_done;
  logic                r_error;

  logic                w_accept;
  logic                w_legal;
  logic                w_tick;
  logic                w_ramp;
  logic                w_phase_last;
  logic [PHASE_W-1:0]  w_phase_max;
  logic [STEP_W-1:0]   w_target;
  logic [5:0]          w_face_onehot;

  assign w_accept      = cmd.cmd_valid && (r_state == S_IDLE);
  assign w_legal       = cmd.cmd_face < 3'd6;
  assign w_tick        = (r_state != S_IDLE) && (r_tick_cnt == LAST_TICK);
  assign w_target      = r_half ? N_HALF : N_QUARTER;
  assign w_face_onehot = 6'b000001 << r_face;

`ifdef MOVE_SEQUENCER_RAMP_EN
  // In STEP_LO the counter already holds the 1-based number of the pulse just emitted.
  assign w_ramp = (r_step_cnt <= STEP_W'(4)) || ((r_step_cnt + STEP_W'(4)) > w_target);
`else
  assign w_ramp = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_phase_max = SETTLE_LAST;
    if (r_state == S_STEP_LO) begin
      w_phase_max = w_ramp ? PHASE_W'(2) : PHASE_W'(0);
    end
  end

  assign w_phase_last = (r_phase_cnt == w_phase_max);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && w_legal)     w_next_state = S_ENABLE;
      S_ENABLE:  if (w_tick && w_phase_last)  w_next_state = S_STEP_HI;
      S_STEP_HI: if (w_tick)                  w_next_state = S_STEP_LO;
      S_STEP_LO: if (w_tick && w_phase_last)
                   w_next_state = (r_step_cnt < w_target) ? S_STEP_HI : S_HOLD;
      S_HOLD:    if (w_tick && w_phase_last)  w_next_state = S_IDLE;
      default:                                w_next_state = S_IDLE;
    endcase
  end

  // Pin outputs decode straight from the state, so they drop on the same edge IDLE is entered.
  always_comb begin
    cmd.cmd_ready = 1'b0;
    o_busy        = 1'b0;
    o_step        = 6'b0;
    o_dir         = 6'b0;
    o_enable      = 6'b0;
    if (r_state == S_IDLE) begin
      cmd.cmd_ready = 1'b1;
    end else begin
      o_busy   = 1'b1;
      o_enable = w_face_onehot;
      o_dir    = r_dir ? w_face_onehot : 6'b0;
      if (r_state == S_STEP_HI) begin
        o_step = w_face_onehot;
      end
    end
  end

  assign o_done  = r_done;
  assign o_error = r_error;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_phase_cnt <= '0;
      r_step_cnt  <= '0;
      r_face      <= '0;
      r_dir       <= 1'b0;
      r_half      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_accept) begin
        r_tick_cnt  <= '0;
        r_phase_cnt <= '0;
        r_step_cnt  <= '0;
        if (w_legal) begin
          r_face <= cmd.cmd_face;
          r_dir  <= cmd.cmd_dir;
          r_half <= cmd.cmd_half;
        end else begin
          r_error <= 1'b1;
        end
      end else if (r_state != S_IDLE) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        if (w_tick) begin
          // STEP_HI lasts exactly one tick; the other states count ticks in r_phase_cnt.
          if (r_state == S_STEP_HI) begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
          end else begin
            r_phase_cnt <= w_phase_last ? '0 : r_phase_cnt + PHASE_W'(1);
          end
          if ((r_state == S_HOLD) && w_phase_last) begin
            r_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with TICK_DIV=4, STEPS_PER_QUARTER=3, SETTLE_TICKS=2.
// A vector table covers single moves; hand-written sequences cover reset mid-move and back-to-back.
module tb_move_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [5:0] o_step;
  logic [5:0] o_dir;
  logic [5:0] o_enable;

  int n_checks = 0;
  int n_fail   = 0;

  move_sequencer_if cmd ();

  move_sequencer #(
    .TICK_DIV          (4),
    .STEPS_PER_QUARTER (3),
    .SETTLE_TICKS      (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error),
    .o_step   (o_step),
    .o_dir    (o_dir),
    .o_enable (o_enable)
  );

  always #20 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] face;
    logic       dir;
    logic       half;
    int         exp_lat;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one command and checks the whole move (or the error pulse for an illegal face).
  task automatic run_move(input logic [2:0] f, input logic d, input logic h,
                          input int exp_lat, input int exp_pulses, input string tag);
    logic [5:0] exp_en;
    logic [5:0] exp_dir;
    logic [5:0] en_at_done;
    logic [5:0] step_at_done;
    logic       busy_at_done;
    logic       prev;
    int done_k, pulses, width, bad_width, bad_en, bad_other, err_cnt, err_k0;
    exp_en       = 6'b000001 << f;
    exp_dir      = d ? exp_en : 6'b0;
    done_k       = -1;
    pulses       = 0;
    width        = 0;
    bad_width    = 0;
    bad_en       = 0;
    bad_other    = 0;
    err_cnt      = 0;
    err_k0       = 0;
    prev         = 1'b0;
    en_at_done   = 6'h3f;
    step_at_done = 6'h3f;
    busy_at_done = 1'b1;

    @(negedge clock);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_face  = f;
    cmd.cmd_dir   = d;
    cmd.cmd_half  = h;
    @(posedge clock);
    #1 cmd.cmd_valid = 1'b0;

    if (f < 3'd6) begin
      for (int k = 0; k < 400; k++) begin
        @(negedge clock);
        if (o_done) begin
          done_k       = k;
          en_at_done   = o_enable;
          step_at_done = o_step;
          busy_at_done = o_busy;
          break;
        end
        if (o_enable !== exp_en || o_dir !== exp_dir || !o_busy || cmd.cmd_ready) bad_en++;
        if ((o_step & ~exp_en) != 6'b0 || o_error) bad_other++;
        if (o_step[f]) begin
          if (!prev) pulses++;
          width++;
        end else if (prev) begin
          if (width != 4) bad_width++;
          width = 0;
        end
        prev = o_step[f];
      end
      check({tag, ".done_latency"}, done_k, exp_lat);
      check({tag, ".pulses"}, pulses, exp_pulses);
      check({tag, ".bad_pulse_width"}, bad_width, 0);
      check({tag, ".bad_enable_dir_busy"}, bad_en, 0);
      check({tag, ".stray_step_or_error"}, bad_other, 0);
      check({tag, ".enable_at_done"}, en_at_done, 0);
      check({tag, ".step_busy_at_done"}, {step_at_done, busy_at_done}, 0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (o_error) begin
          err_cnt++;
          if (k == 0) err_k0 = 1;
        end
        if (o_busy || o_done || o_step != 6'b0 || o_enable != 6'b0 || !cmd.cmd_ready) bad_other++;
      end
      check({tag, ".error_pulses"}, err_cnt, 1);
      check({tag, ".error_next_cycle"}, err_k0, 1);
      check({tag, ".no_motion"}, bad_other, 0);
    end
  endtask

  initial begin
    int bad;
    int done_cnt;
    int pulse_no;
    int done1_k, done2_k, overlap;
    logic [5:0] en_at_41;
    logic       prev;

    vecs[0] = '{face: 3'd2, dir: 1'b1, half: 1'b0, exp_lat: 40, exp_pulses: 3};
    vecs[1] = '{face: 3'd5, dir: 1'b0, half: 1'b1, exp_lat: 64, exp_pulses: 6};
    vecs[2] = '{face: 3'd7, dir: 1'b1, half: 1'b0, exp_lat: 0,  exp_pulses: 0};
    vecs[3] = '{face: 3'd6, dir: 1'b0, half: 1'b1, exp_lat: 0,  exp_pulses: 0};
    vecs[4] = '{face: 3'd0, dir: 1'b0, half: 1'b0, exp_lat: 40, exp_pulses: 3};
`ifdef MOVE_SEQUENCER_RAMP_EN
    // Every pulse is ramped when N <= 8: 2 extra ticks (8 cycles) per pulse.
    vecs[0].exp_lat = 64;
    vecs[1].exp_lat = 112;
    vecs[4].exp_lat = 64;
`endif

    cmd.cmd_valid = 1'b0;
    cmd.cmd_face  = 3'd0;
    cmd.cmd_dir   = 1'b0;
    cmd.cmd_half  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!cmd.cmd_ready || o_busy || o_done || o_error ||
          o_step != 6'b0 || o_dir != 6'b0 || o_enable != 6'b0) bad++;
    end
    check("idle.cmd_ready", cmd.cmd_ready, 1);
    check("idle.outputs_quiet", bad, 0);

    for (int i = 0; i < 5; i++) begin
      run_move(vecs[i].face, vecs[i].dir, vecs[i].half,
               vecs[i].exp_lat, vecs[i].exp_pulses, $sformatf("vec%0d", i));
    end

    // Reset asserted during the second step pulse of a face-1 move
    @(negedge clock);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_face  = 3'd1;
    cmd.cmd_dir   = 1'b1;
    cmd.cmd_half  = 1'b0;
    @(posedge clock);
    #1 cmd.cmd_valid = 1'b0;
    pulse_no = 0;
    prev     = 1'b0;
    for (int k = 0; k < 200 && pulse_no < 2; k++) begin
      @(negedge clock);
      if (o_step[1] && !prev) pulse_no++;
      prev = o_step[1];
    end
    check("rst_mid.reached_pulse2", pulse_no, 2);
    @(negedge clock);
    check("rst_mid.still_stepping", o_step, 6'b000010);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid.step", o_step, 0);
    check("rst_mid.enable", o_enable, 0);
    check("rst_mid.busy_dir", {o_busy, o_dir}, 0);
    check("rst_mid.cmd_ready", cmd.cmd_ready, 1);
    done_cnt = 0;
    bad      = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (o_done) done_cnt++;
      if (o_busy || o_enable != 6'b0 || o_step != 6'b0) bad++;
    end
    check("rst_mid.no_done", done_cnt, 0);
    check("rst_mid.stays_idle", bad, 0);
    run_move(3'd3, 1'b1, 1'b0, vecs[0].exp_lat, 3, "after_rst");

    // Back-to-back with cmd_valid held high: face 0 then face 1
    done1_k  = -1;
    done2_k  = -1;
    overlap  = 0;
    en_at_41 = 6'h3f;
    @(negedge clock);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_face  = 3'd0;
    cmd.cmd_dir   = 1'b1;
    cmd.cmd_half  = 1'b0;
    @(posedge clock);
    #1 cmd.cmd_face = 3'd1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (o_enable[0] && o_enable[1]) overlap++;
      if (o_done) begin
        if (done1_k < 0) begin
          done1_k = k;
        end else begin
          done2_k = k;
          break;
        end
      end
      if (done1_k >= 0 && k == done1_k + 1) begin
        en_at_41      = o_enable;
        cmd.cmd_valid = 1'b0;
      end
    end
    cmd.cmd_valid = 1'b0;
    check("b2b.first_done", done1_k, vecs[0].exp_lat);
    check("b2b.second_enable", en_at_41, 6'b000010);
    check("b2b.second_done", done2_k, 2 * vecs[0].exp_lat + 1);
    check("b2b.enable_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
